audio_pwm_player: RTL
=====================

Name: audio_pwm_player

Overview:
- Downstream consumer of the Audio_Controller AXI4-Lite register bank.
- Takes decoded register fields (control, tone half-period, volume, sample writes) and produces a 1-bit PWM audio stream plus an amplifier enable.
- Two sources: a square-wave tone generator, or a streamed 8-bit sample FIFO paced at a fixed sample rate.

Parameters:
- SAMPLE_DIV, 2268, ACLK cycles per sample tick (about 44.1 kHz at 100 MHz); legal range ≥ 2.
- PWM_BITS, 8, PWM counter and sample width.
- FIFO_DEPTH, 16, sample FIFO entries; must be a power of 2.

Ports:
- ACLK  in  1  system clock.
- ARESET  in  1  synchronous, active-high reset.
- ctrl_enable  in  1  playback enable (reg0[0]).
- ctrl_mode  in  1  0 = tone, 1 = stream (reg0[1]).
- tone_half_period  in  32  ACLK cycles per square-wave half cycle (reg1).
- volume  in  PWM_BITS  amplitude/scale (reg2[7:0]).
- sample_data  in  PWM_BITS  sample to push (reg3[7:0]).
- sample_wr  in  1  1-cycle push strobe on a reg3 write.
- underrun_clr  in  1  clears the underrun flag.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_empty  out  1  FIFO holds 0 entries.
- underrun  out  1  sticky flag: a tick occurred in STREAM with the FIFO empty.
- sample_tick  out  1  1-cycle pulse every SAMPLE_DIV cycles while not IDLE.
- amp_en  out  1  high in TONE or STREAM.
- pwm_out  out  1  registered PWM audio.

Behaviour:
- Reset: all outputs 0 except fifo_empty = 1. FIFO emptied, all counters 0, state IDLE.
- State machine:
  - IDLE → TONE when ctrl_enable & !ctrl_mode; IDLE → STREAM when ctrl_enable & ctrl_mode.
  - TONE or STREAM → IDLE the cycle after ctrl_enable falls or ctrl_mode changes. A mode change therefore passes through IDLE for at least one cycle.
- IDLE: pwm_out = 0, amp_en = 0. Tick, tone and PWM counters held at 0. duty = 0.
- Tick counter: counts 0..SAMPLE_DIV-1. sample_tick is asserted on the cycle the counter equals SAMPLE_DIV-1, then the counter wraps.
- TONE:
  - Half-period counter toggles `sq` every tone_half_period cycles.
  - tone_half_period = 0 holds sq = 0 (silence).
  - next_duty = sq ? volume : 0.
- STREAM:
  - On sample_tick with FIFO not empty: pop, next_duty = (sample × volume) >> PWM_BITS. The product is 16 bits wide; keep the upper 8.
  - On sample_tick with FIFO empty: next_duty = 0 and underrun set.
  - underrun_clr and a set in the same cycle: set wins.
- PWM:
  - Free-running pwm_cnt over 0..2^PWM_BITS-1.
  - duty ← next_duty only when pwm_cnt = 0 (glitch-free).
  - pwm_out registered as (pwm_cnt < duty). duty 0 → always low; duty 255 → high 255 of 256 cycles.
- FIFO push:
  - sample_wr is accepted in any state, including IDLE.
  - A push when full and no pop in that cycle is dropped silently.
  - Push and pop in the same cycle when full: both occur, occupancy unchanged.
  - Push and tick in the same cycle when empty: underrun is set and the pushed sample is stored (no bypass).
- FIFO flush: leaving STREAM flushes the FIFO; fifo_empty = 1 on the following cycle.
- Reset mid-playback has the same effect as power-on reset; no partial state survives.

Decomposition:
- audio_pkg holds:
  - state enum {IDLE, TONE, STREAM}
  - MODE_TONE / MODE_STREAM constants
  - PWM_BITS default
  - sample_t typedef
- Sub-module audio_sample_fifo: synchronous FIFO with push, pop, flush, full and empty. Pointers are one bit wider than the address.

Test Plan:
1. Hold ARESET 5 cycles → pwm_out = 0, amp_en = 0, underrun = 0, fifo_empty = 1, fifo_full = 0.
2. TONE, half_period = 1024, volume = 0x80 → pwm_out high 128 of every 256 cycles while sq = 1 and 0 while sq = 0; sq toggles every 1024 cycles; amp_en = 1.
3. STREAM, SAMPLE_DIV = 8, volume = 0xFF, push 0xFF then 0x80 → duty 0xFE after the first tick and 0x7F after the second, each applied at the next pwm_cnt = 0.
4. STREAM with FIFO empty, one tick → underrun = 1 and pwm_out stays 0; pulse underrun_clr → underrun = 0 next cycle.
5. 17 pushes in IDLE → fifo_full = 1 after the 16th; the 17th is dropped; 16 pops return the first 16 samples in order.
6. Drop ctrl_enable mid-STREAM with 5 entries queued → next cycle IDLE: pwm_out = 0, amp_en = 0, fifo_empty = 1.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared state encoding, mode constants and sample type for the PWM audio player.
package audio_pkg;
   localparam int PWM_BITS_DFLT = 8;

   localparam logic MODE_TONE   = 1'b0;
   localparam logic MODE_STREAM = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TONE   = 2'd1,
      STREAM = 2'd2
   } state_t;

   typedef logic [PWM_BITS_DFLT-1:0] sample_t;
endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous show-ahead sample FIFO: entry readable the cycle after push; flush empties it in one cycle.
// No backpressure: a push into a full FIFO without a same-cycle pop is dropped, a pop when empty is ignored.
module audio_sample_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_head_dat,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer bit distinguishes full from empty when the addresses match.
   assign o_empty    = (r_wr_ptr == r_rd_ptr);
   assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop   = i_pop && !o_empty;
   assign w_do_push  = i_push && !i_flush && (!o_full || w_do_pop);
   assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
   end
endmodule

// File: rtl/audio_pwm_player.sv
// PWM audio player: square tone or FIFO-streamed samples scaled by volume; pwm_out is one register after the duty compare.
// No backpressure: pushes into a full FIFO are dropped, a sample tick with the FIFO empty sets the sticky underrun flag.
module audio_pwm_player
   import audio_pkg::*;
#(
   parameter int SAMPLE_DIV = 2268,
   parameter int PWM_BITS   = PWM_BITS_DFLT,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                ctrl_enable,
   input  logic                ctrl_mode,
   input  logic [31:0]         tone_half_period,
   input  logic [PWM_BITS-1:0] volume,
   input  logic [PWM_BITS-1:0] sample_data,
   input  logic                sample_wr,
   input  logic                underrun_clr,
   output logic                fifo_full,
   output logic                fifo_empty,
   output logic                underrun,
   output logic                sample_tick,
   output logic                amp_en,
   output logic                pwm_out
);
   localparam int TW = $clog2(SAMPLE_DIV);

   state_t                  r_state;
   state_t                  w_next_state;
   logic                    w_active;
   logic                    w_in_tone;
   logic                    w_in_stream;
   logic                    w_flush;
   logic                    w_tick;
   logic                    w_pop;
   logic [TW-1:0]           r_tick_cnt;
   logic [31:0]             r_half_cnt;
   logic                    r_sq;
   logic [PWM_BITS-1:0]     w_fifo_head;
   logic [2*PWM_BITS-1:0]   w_product;
   logic [PWM_BITS-1:0]     r_stream_duty;
   logic [PWM_BITS-1:0]     w_next_duty;
   logic [PWM_BITS-1:0]     r_duty;
   logic [PWM_BITS-1:0]     r_pwm_cnt;
   logic                    r_pwm_out;
   logic                    r_underrun;

   always_ff @(posedge ACLK) begin
      if (ARESET) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // A mode change while playing always drops back through IDLE first.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (ctrl_enable)
                     w_next_state = (ctrl_mode == MODE_STREAM) ? STREAM : TONE;
         TONE:    if (!ctrl_enable || ctrl_mode != MODE_TONE)   w_next_state = IDLE;
         STREAM:  if (!ctrl_enable || ctrl_mode != MODE_STREAM) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      w_active    = (r_state != IDLE);
      w_in_tone   = (r_state == TONE);
      w_in_stream = (r_state == STREAM);
      w_flush     = w_in_stream && (w_next_state != STREAM);
   end

   assign amp_en      = w_active;
   assign w_tick      = w_active && (r_tick_cnt == TW'(SAMPLE_DIV - 1));
   assign sample_tick = w_tick;
   assign w_pop       = w_tick && w_in_stream;

   always_ff @(posedge ACLK) begin
      if (ARESET || !w_active) r_tick_cnt <= '0;
      else if (w_tick)         r_tick_cnt <= '0;
      else                     r_tick_cnt <= r_tick_cnt + 1'b1;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET || !w_in_tone || tone_half_period == 32'd0) begin
         r_half_cnt <= '0;
         r_sq       <= 1'b0;
      end else if (r_half_cnt == tone_half_period - 32'd1) begin
         r_half_cnt <= '0;
         r_sq       <= !r_sq;
      end else begin
         r_half_cnt <= r_half_cnt + 32'd1;
      end
   end

   audio_sample_fifo #(
      .WIDTH (PWM_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (ACLK),
      .i_rst      (ARESET),
      .i_push     (sample_wr),
      .i_push_dat (sample_data),
      .i_pop      (w_pop),
      .i_flush    (w_flush),
      .o_head_dat (w_fifo_head),
      .o_full     (fifo_full),
      .o_empty    (fifo_empty)
   );

   assign w_product = {{PWM_BITS{1'b0}}, w_fifo_head} * {{PWM_BITS{1'b0}}, volume};

   always_ff @(posedge ACLK) begin
      if (ARESET || !w_in_stream) r_stream_duty <= '0;
      else if (w_pop)             r_stream_duty <= fifo_empty ? '0 : w_product[2*PWM_BITS-1:PWM_BITS];
   end

   always_ff @(posedge ACLK) begin
      if (ARESET)                   r_underrun <= 1'b0;
      else if (w_pop && fifo_empty) r_underrun <= 1'b1;
      else if (underrun_clr)        r_underrun <= 1'b0;
   end

   assign underrun = r_underrun;

   always_comb begin
      w_next_duty = '0;
      if (w_in_tone)        w_next_duty = r_sq ? volume : '0;
      else if (w_in_stream) w_next_duty = r_stream_duty;
   end

   // Duty only changes at the period boundary so a PWM period is never split.
   always_ff @(posedge ACLK) begin
      if (ARESET || !w_active) begin
         r_pwm_cnt <= '0;
         r_duty    <= '0;
         r_pwm_out <= 1'b0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
         if (r_pwm_cnt == '0) r_duty <= w_next_duty;
         r_pwm_out <= (w_next_state != IDLE) && (r_pwm_cnt < r_duty);
      end
   end

   assign pwm_out = r_pwm_out;
endmodule
